// File: rtl/mem_pkg.sv
// Shared layout for the MEM response stage: bus field offsets, load-op codes and
// the entry state encoding.
package mem_pkg;

    localparam int EX_BUS_W = 75;
    localparam int WB_BUS_W = 70;
    localparam int FWD_W    = 40;

    // ex_bus = {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0], ld_op[2:0], req_sent}
    localparam int EX_REQ_SENT   = 0;
    localparam int EX_LD_OP_LSB  = 1;
    localparam int EX_PC_LSB     = 4;
    localparam int EX_ALU_LSB    = 36;
    localparam int EX_DEST_LSB   = 68;
    localparam int EX_GR_WE      = 73;
    localparam int EX_RES_MEM    = 74;

    // wb_bus = {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
    localparam int WB_PC_LSB     = 0;
    localparam int WB_RESULT_LSB = 32;
    localparam int WB_DEST_LSB   = 64;
    localparam int WB_GR_WE      = 69;

    // mem_fwd = {mem_valid, gr_we, dest[4:0], result[31:0], data_pending}
    localparam int FWD_PENDING    = 0;
    localparam int FWD_RESULT_LSB = 1;
    localparam int FWD_DEST_LSB   = 33;
    localparam int FWD_GR_WE      = 38;
    localparam int FWD_VALID      = 39;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        byte_sel = data[7:0];
        result   = data;
        case (addr_lo)
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            2'd3:    byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'b0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'b0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// Single-entry MEM stage: waits for the data-SRAM response, aligns loads and hands off to WB.
// Define MEM_LOAD_BYPASS_EN to forward load data on mem_fwd in the response cycle itself.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int EX_W  = EX_BUS_W,
    parameter int WB_W  = WB_BUS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [EX_W-1:0]  ex_bus,
    output logic             mem_allow,
    input  logic             wb_allow,
    output logic             wb_valid,
    output logic [WB_W-1:0]  wb_bus,
    input  logic             data_ok,
    input  logic [31:0]      rdata,
    input  logic             flush,
    output logic [FWD_W-1:0] mem_fwd
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state, state_nxt;
    logic [EX_W-1:0]  payload;
    logic [31:0]      rdata_buf;
    logic [CNT_W-1:0] discard_cnt;
    logic             mem_valid, resp_hit, ready_go, accept, cnt_inc, cnt_dec;

    logic        res_from_mem, gr_we, req_sent;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;
    logic [2:0]  ld_op;
    logic [31:0] load_src, load_result, final_result;
    logic        fwd_pending;
    logic [31:0] fwd_result;

    assign res_from_mem = payload[EX_RES_MEM];
    assign gr_we        = payload[EX_GR_WE];
    assign dest         = payload[EX_DEST_LSB +: 5];
    assign alu_result   = payload[EX_ALU_LSB +: 32];
    assign pc           = payload[EX_PC_LSB +: 32];
    assign ld_op        = payload[EX_LD_OP_LSB +: 3];
    assign req_sent     = payload[EX_REQ_SENT];

    always_comb begin
        state_nxt = state;
        mem_valid = (state != ST_EMPTY);
        resp_hit  = (state == ST_WAIT) && data_ok && (discard_cnt == '0);
        ready_go  = (state == ST_READY) || resp_hit;
        // A flushed entry is never offered to WB, even in its response cycle.
        wb_valid  = mem_valid && ready_go && !flush;
        mem_allow = (!mem_valid || (ready_go && wb_allow)) && (discard_cnt != CNT_MAX);
        accept    = ex_valid && mem_allow && !flush;
        if (flush)
            state_nxt = ST_EMPTY;
        else if (accept)
            state_nxt = ex_bus[EX_REQ_SENT] ? ST_WAIT : ST_READY;
        else if (wb_valid && wb_allow)
            state_nxt = ST_EMPTY;
        else if (resp_hit)
            state_nxt = ST_READY;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Responses still owed to flushed requests arrive first and are dropped.
    assign cnt_inc = flush && (state == ST_WAIT) && !resp_hit;
    assign cnt_dec = data_ok && (discard_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset)
            discard_cnt <= '0;
        else if (cnt_inc && !cnt_dec)
            discard_cnt <= discard_cnt + CNT_ONE;
        else if (cnt_dec && !cnt_inc)
            discard_cnt <= discard_cnt - CNT_ONE;
    end

    // NOTE: payload and rdata_buf are data-only registers qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept)
            payload <= ex_bus;
        if (resp_hit)
            rdata_buf <= rdata;
    end

    assign load_src     = (state == ST_WAIT) ? rdata : rdata_buf;
    assign final_result = res_from_mem ? load_result : alu_result;

    load_align u_load_align (
        .ld_op   (ld_op),
        .addr_lo (alu_result[1:0]),
        .data    (load_src),
        .result  (load_result)
    );

    always_comb begin
        wb_bus = '0;
        wb_bus[WB_GR_WE]              = gr_we;
        wb_bus[WB_DEST_LSB +: 5]      = dest;
        wb_bus[WB_RESULT_LSB +: 32]   = final_result;
        wb_bus[WB_PC_LSB +: 32]       = pc;
    end

    always_comb begin
`ifdef MEM_LOAD_BYPASS_EN
        fwd_pending = (state == ST_WAIT) && res_from_mem && !ready_go;
        fwd_result  = final_result;
`else
        // Without bypass the load value is only published once it sits in rdata_buf.
        fwd_pending = (state == ST_WAIT) && res_from_mem;
        fwd_result  = fwd_pending ? 32'h0 : final_result;
`endif
        mem_fwd = '0;
        if (mem_valid) begin
            mem_fwd[FWD_VALID]             = 1'b1;
            mem_fwd[FWD_GR_WE]             = gr_we;
            mem_fwd[FWD_DEST_LSB +: 5]     = dest;
            mem_fwd[FWD_RESULT_LSB +: 32]  = fwd_result;
            mem_fwd[FWD_PENDING]           = fwd_pending;
        end
    end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Self-checking bench for mem_resp_stage: directed scenarios plus random traffic against
// a reference model that tracks outstanding SRAM requests as a queue of live/dead owners.
module tb_mem_resp_stage;
    import mem_pkg::*;

    localparam int CNT_W   = 2;
    localparam int MAX_DEAD = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [74:0] ex_bus;
    logic        mem_allow;
    logic        wb_allow;
    logic        wb_valid;
    logic [69:0] wb_bus;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush;
    logic [39:0] mem_fwd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_resp_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_bus    (ex_bus),
        .mem_allow (mem_allow),
        .wb_allow  (wb_allow),
        .wb_valid  (wb_valid),
        .wb_bus    (wb_bus),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .flush     (flush),
        .mem_fwd   (mem_fwd)
    );

    // Fields of the instruction currently offered on ex_bus.
    bit        t_res_mem, t_gr_we, t_req_sent;
    bit [4:0]  t_dest;
    bit [31:0] t_alu, t_pc;
    bit [2:0]  t_ld_op;

    typedef struct {
        bit        valid;
        bit        waiting;
        bit        res_mem;
        bit        gr_we;
        bit [4:0]  dest;
        bit [31:0] alu;
        bit [31:0] pc;
        bit [2:0]  ld_op;
        bit [31:0] data;
    } entry_t;

    entry_t ent;
    bit     owners[$];   // one per outstanding request, 1 = belongs to the live entry
    bit     exp_wbv, exp_allow;

    task automatic check(input string tag, input logic [69:0] observed, input logic [69:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] extract(input bit [2:0] op, input bit [1:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b ^ 32'h80) - 32'h80;
            3'd2:    return b;
            3'd3:    return (h ^ 32'h8000) - 32'h8000;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    // Drive ex_bus, let the combinational outputs settle, compare against the model.
    task automatic eval(input string tag);
        bit          live, has_data, pend;
        int          dead;
        logic [31:0] res;
        ex_bus = {t_res_mem, t_gr_we, t_dest, t_alu, t_pc, t_ld_op, t_req_sent};
        #1;
        dead = 0;
        foreach (owners[i]) if (!owners[i]) dead++;
        live     = data_ok && (owners.size() > 0) && owners[0];
        has_data = ent.valid && (!ent.waiting || live);
        res      = ent.res_mem ? extract(ent.ld_op, ent.alu[1:0], live ? rdata : ent.data) : ent.alu;
        exp_wbv   = has_data && !flush;
        exp_allow = (!ent.valid || (has_data && wb_allow)) && (dead < MAX_DEAD);
        check({tag, ".wb_valid"}, 70'(wb_valid), 70'(exp_wbv));
        check({tag, ".mem_allow"}, 70'(mem_allow), 70'(exp_allow));
        if (exp_wbv)
            check({tag, ".wb_bus"}, wb_bus, {ent.gr_we, ent.dest, res, ent.pc});
        pend = ent.valid && ent.waiting && ent.res_mem;
`ifdef MEM_LOAD_BYPASS_EN
        pend = pend && !live;
`endif
        if (!ent.valid)
            check({tag, ".fwd_idle"}, 70'({mem_fwd[39], mem_fwd[37:33]}), 70'(0));
        else begin
            check({tag, ".fwd_hdr"}, 70'({mem_fwd[39:33], mem_fwd[0]}),
                  70'({1'b1, ent.gr_we, ent.dest, pend}));
            if (!pend)
                check({tag, ".fwd_result"}, 70'(mem_fwd[32:1]), 70'(res));
        end
    endtask

    // Clock edge plus model update; returns 1 time unit after the edge.
    task automatic advance();
        bit acc;
        acc = ex_valid && exp_allow && !flush;
        @(posedge clk);
        if (data_ok && owners.size() > 0) begin
            if (owners[0]) begin
                ent.waiting = 1'b0;
                ent.data    = rdata;
            end
            void'(owners.pop_front());
        end
        if (flush) begin
            foreach (owners[i]) owners[i] = 1'b0;
            ent.valid = 1'b0;
        end else if (acc) begin
            ent = '{1'b1, t_req_sent, t_res_mem, t_gr_we, t_dest, t_alu, t_pc, t_ld_op, 32'h0};
            if (t_req_sent) owners.push_back(1'b1);
        end else if (exp_wbv && wb_allow) begin
            ent.valid = 1'b0;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        eval(tag);
        advance();
    endtask

    task automatic set_op(input bit res_mem, input bit [2:0] op, input bit [31:0] alu, input bit req);
        t_res_mem  = res_mem;
        t_gr_we    = 1'b1;
        t_dest     = 5'($urandom_range(1, 31));
        t_alu      = alu;
        t_pc       = $urandom;
        t_ld_op    = op;
        t_req_sent = req;
    endtask

    initial begin
        reset    = 1'b1;
        ex_valid = 1'b0;
        wb_allow = 1'b1;
        data_ok  = 1'b0;
        flush    = 1'b0;
        rdata    = 32'h0;
        set_op(1'b0, LD_W, 32'h0, 1'b0);
        ex_bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        eval("reset");
        check("reset.mem_fwd", 70'(mem_fwd), 70'(0));
        check("reset.mem_allow", 70'(mem_allow), 70'(1));
        check("reset.wb_valid", 70'(wb_valid), 70'(0));
        reset = 1'b0;
        advance();

        // ld.b, byte 2 of 0x80FF0000, response three cycles after acceptance
        set_op(1'b1, LD_B, 32'h1000_0002, 1'b1);
        ex_valid = 1'b1;
        cycle("ldb.acc");
        ex_valid = 1'b0;
        cycle("ldb.w1");
        cycle("ldb.w2");
        data_ok = 1'b1;
        rdata   = 32'h80FF_0000;
        eval("ldb.resp");
        check("ldb.wb_valid", 70'(wb_valid), 70'(1));
        check("ldb.result", 70'(wb_bus[63:32]), 70'(32'hFFFF_FFFF));
        advance();
        data_ok = 1'b0;
        rdata   = $urandom;
        eval("ldb.after");
        check("ldb.one_cycle", 70'(wb_valid), 70'(0));
        advance();

        // ld.hu upper half, WB back-pressured for two cycles
        set_op(1'b1, LD_HU, 32'h2000_0002, 1'b1);
        ex_valid = 1'b1;
        cycle("ldhu.acc");
        ex_valid = 1'b0;
        wb_allow = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h1234_ABCD;
        cycle("ldhu.resp");
        data_ok  = 1'b0;
        rdata    = $urandom;
        eval("ldhu.held");
        check("ldhu.held_valid", 70'(wb_valid), 70'(1));
        advance();
        wb_allow = 1'b1;
        eval("ldhu.take");
        check("ldhu.result", 70'(wb_bus[63:32]), 70'(32'h0000_1234));
        advance();
        eval("ldhu.gone");
        check("ldhu.retired", 70'(wb_valid), 70'(0));
        advance();

        // flush in WAIT: the stale response is dropped, the next one belongs to the new load
        set_op(1'b1, LD_W, 32'h3000_0000, 1'b1);
        ex_valid = 1'b1;
        cycle("fl.acc");
        ex_valid = 1'b0;
        flush    = 1'b1;
        cycle("fl.flush");
        flush = 1'b0;
        eval("fl.empty");
        check("fl.fwd_dest_gated", 70'({mem_fwd[39], mem_fwd[37:33]}), 70'(0));
        advance();
        set_op(1'b1, LD_W, 32'h3000_0004, 1'b1);
        ex_valid = 1'b1;
        cycle("fl.acc2");
        ex_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h0000_DEAD;
        eval("fl.stale");
        check("fl.stale_dropped", 70'(wb_valid), 70'(0));
        advance();
        rdata = 32'h0000_0005;
        eval("fl.real");
        check("fl.real_valid", 70'(wb_valid), 70'(1));
        check("fl.real_result", 70'(wb_bus[63:32]), 70'(32'h5));
        advance();
        data_ok = 1'b0;
        set_op(1'b1, LD_W, 32'h3000_0008, 1'b1);
        ex_valid = 1'b1;
        cycle("fl.acc3");
        ex_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h0000_0077;
        eval("fl.cnt_clear");
        check("fl.cnt_clear_fwd", 70'(wb_valid), 70'(1));
        advance();
        data_ok = 1'b0;

        // flush coincident with the response: consumed, not forwarded, nothing owed
        set_op(1'b1, LD_W, 32'h4000_0000, 1'b1);
        ex_valid = 1'b1;
        cycle("co.acc");
        ex_valid = 1'b0;
        flush    = 1'b1;
        data_ok  = 1'b1;
        rdata    = 32'h0000_0BAD;
        eval("co.flush");
        check("co.no_wb", 70'(wb_valid), 70'(0));
        advance();
        flush   = 1'b0;
        data_ok = 1'b0;
        eval("co.after");
        check("co.no_wb_after", 70'(wb_valid), 70'(0));
        advance();
        set_op(1'b1, LD_W, 32'h4000_0004, 1'b1);
        ex_valid = 1'b1;
        cycle("co.acc2");
        ex_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'h0000_0099;
        eval("co.next");
        check("co.cnt_zero_fwd", 70'(wb_valid), 70'(1));
        advance();
        data_ok = 1'b0;

        // three flushed loads saturate the discard counter
        for (int k = 0; k < 3; k++) begin
            set_op(1'b1, LD_W, 32'h5000_0000, 1'b1);
            ex_valid = 1'b1;
            cycle("sat.acc");
            ex_valid = 1'b0;
            flush    = 1'b1;
            cycle("sat.flush");
            flush = 1'b0;
        end
        set_op(1'b0, LD_W, 32'h0000_0011, 1'b0);
        ex_valid = 1'b1;
        eval("sat.full");
        check("sat.blocked", 70'(mem_allow), 70'(0));
        advance();
        eval("sat.still");
        check("sat.still_blocked", 70'(mem_allow), 70'(0));
        advance();
        ex_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = $urandom;
        cycle("sat.drain1");
        data_ok = 1'b0;
        eval("sat.open");
        check("sat.reopened", 70'(mem_allow), 70'(1));
        advance();
        data_ok = 1'b1;
        cycle("sat.drain2");
        cycle("sat.drain3");
        data_ok = 1'b0;

        // ex_valid is ignored in a flush cycle
        set_op(1'b0, LD_W, 32'h0000_0055, 1'b0);
        ex_valid = 1'b1;
        flush    = 1'b1;
        cycle("fi.flush");
        ex_valid = 1'b0;
        flush    = 1'b0;
        eval("fi.after");
        check("fi.ignored", 70'(wb_valid), 70'(0));
        advance();

        // plain ALU op goes to WB the cycle after acceptance
        set_op(1'b0, LD_W, 32'h0000_0042, 1'b0);
        ex_valid = 1'b1;
        cycle("alu.acc");
        ex_valid = 1'b0;
        eval("alu.wb");
        check("alu.wb_valid", 70'(wb_valid), 70'(1));
        check("alu.result", 70'(wb_bus[63:32]), 70'(32'h42));
        check("alu.pending", 70'(mem_fwd[0]), 70'(0));
        advance();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            set_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1'b0);
            t_gr_we    = 1'($urandom_range(0, 1));
            t_req_sent = t_res_mem | ($urandom_range(0, 3) == 0);
            ex_valid   = ($urandom_range(0, 1) == 1);
            wb_allow   = ($urandom_range(0, 3) != 0);
            data_ok    = (owners.size() > 0) && ($urandom_range(0, 2) == 0);
            rdata      = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of the discarded-response counter.
REQ-002 SHALL have parameter EX_W, default 75, width of ex_bus; fixed by the package layout.
REQ-003 SHALL have parameter WB_W, default 70, width of wb_bus; fixed by the package layout.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: ex_valid in 1, EX entry offered; ex_bus in EX_W, EX payload; mem_allow out 1, stage can accept.
REQ-006 SHALL have ports: wb_allow in 1, WB can accept; wb_valid out 1, entry offered to WB; wb_bus out WB_W, {gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
REQ-007 SHALL have ports: data_ok in 1, data-SRAM response strobe; rdata in 32, response data; flush in 1, exception/ertn flush.
REQ-008 SHALL have port mem_fwd out 40: {mem_valid, gr_we, dest, result[31:0], data_pending}.

Function
REQ-009 SHALL decode ex_bus as {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0], ld_op[2:0], req_sent}, MSB first.
REQ-010 SHALL use ld_op encoding: 000 word, 001 ld.b, 010 ld.bu, 011 ld.h, 100 ld.hu; other codes treated as word.
REQ-011 SHALL hold one entry in states EMPTY, WAIT and READY.
REQ-012 SHALL enter WAIT on acceptance when req_sent=1, otherwise enter READY.
REQ-013 SHALL accept a response in WAIT as data_ok=1 with discard_cnt=0: latch rdata into rdata_buf and move to READY.
REQ-014 SHALL set ready_go = READY or (WAIT and data_ok and discard_cnt==0); wb_valid = mem_valid and ready_go.
REQ-015 SHALL set mem_allow = !mem_valid or (ready_go and wb_allow).
REQ-016 SHALL pass a response straight to WB when wb_allow=1, without an extra cycle; otherwise it holds in READY.
REQ-017 SHALL extract the load byte or halfword using alu_result[1:0], sign- or zero-extended per ld_op; word passes through unchanged.
REQ-018 SHALL take the load data from rdata in the response cycle and from rdata_buf afterwards.
REQ-019 SHALL set final_result to the load result when res_from_mem=1, otherwise to alu_result.
REQ-020 SHALL on flush force mem_valid to 0 in the next cycle and ignore ex_valid in the flush cycle.
REQ-021 SHALL on flush in WAIT with no accepted response that cycle increment discard_cnt.
REQ-022 SHALL decrement discard_cnt on each data_ok while discard_cnt>0 and never forward that rdata.
REQ-023 SHALL apply increment and decrement in the same cycle as a net-zero change.
REQ-024 SHALL hold mem_allow=0 while discard_cnt equals 2^CNT_W-1.
REQ-025 SHALL gate mem_fwd dest to 0 when mem_valid=0.
REQ-026 SHALL set data_pending=1 only in WAIT with res_from_mem=1 and ready_go=0.

Reset
REQ-027 SHALL reset to: state EMPTY, mem_valid 0, discard_cnt 0, wb_valid 0, mem_fwd 0 and mem_allow 1; the payload register is left unreset.

Configuration
REQ-028 SHALL, with MEM_LOAD_BYPASS_EN defined, drive mem_fwd.result from the extracted rdata in the response cycle with data_pending=0.
REQ-029 SHALL, with MEM_LOAD_BYPASS_EN undefined, keep data_pending=1 through the response cycle and present the result from rdata_buf only from the next cycle.

Structure
REQ-030 SHALL place the ex_bus, wb_bus and mem_fwd field offsets, the ld_op codes and the state encoding in package mem_pkg.
REQ-031 SHALL implement the extraction and extension logic as a combinational sub-module load_align.

Verification
REQ-032 SHALL cover: ld.b with req_sent, alu_result[1:0]=2, data_ok after 3 cycles with rdata=0x80FF0000, wb_allow=1 -> wb_bus result 0xFFFFFFFF, wb_valid for 1 cycle.
REQ-033 SHALL cover: ld.hu, data_ok with rdata=0x1234ABCD and wb_allow=0 for 2 cycles -> entry held in READY and WB receives 0x00001234 when wb_allow rises, alu_result[1]=1.
REQ-034 SHALL cover: flush in WAIT, next entry a load, two data_ok (0xDEAD, then 0x5) -> the first is discarded and WB gets 0x5; discard_cnt returns to 0.
REQ-035 SHALL cover: flush coincident with data_ok in WAIT -> discard_cnt stays 0 and there is no wb_valid.
REQ-036 SHALL cover: three flushes in WAIT with no responses, CNT_W=2 -> mem_allow=0 until one data_ok arrives.
REQ-037 SHALL cover: non-memory ALU op with alu_result 0x42 -> wb_valid the cycle after acceptance with result 0x42, and mem_fwd data_pending=0 in both config builds.
